// File: rtl/ceil_div_seq.sv
// Sequential unsigned ceiling divider: radix-2 restoring, one quotient bit per clock.
// Define CEIL_DIV_SEQ_ASSERTS_EN to compile the built-in simulation checkers.
//
// state | meaning
// IDLE  | waiting for an operand pair, in_ready_o high
// BUSY  | WIDTH shift/subtract steps in progress
// DONE  | result held on the outputs until out_ready_i
module ceil_div_seq #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [WIDTH-1:0] quotient_o,
  output logic             div_by_zero_o
);

  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   rem;
  logic [WIDTH-1:0] quo;
  logic [WIDTH-1:0] div;

  logic             in_hs;
  logic [WIDTH+1:0] shifted;
  logic             ge;
  logic [WIDTH:0]   rem_next;
  logic [WIDTH-1:0] quo_next;

  assign in_ready_o  = (state == IDLE);
  assign out_valid_o = (state == DONE);
  assign in_hs       = in_valid_i & in_ready_o;

  // quo starts as the dividend and shifts out MSB-first while quotient bits shift in
  always_comb begin
    shifted  = {rem, quo[WIDTH-1]};
    ge       = (shifted >= {2'b00, div});
    rem_next = ge ? (shifted[WIDTH:0] - {1'b0, div}) : shifted[WIDTH:0];
    quo_next = {quo[WIDTH-2:0], ge};
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state         <= IDLE;
      cnt           <= '0;
      rem           <= '0;
      quo           <= '0;
      div           <= '0;
      quotient_o    <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_hs) begin
            quo <= dividend_i;
            div <= divisor_i;
            rem <= '0;
            cnt <= '0;
            if (divisor_i == '0) begin
              state         <= DONE;
              quotient_o    <= '1;
              div_by_zero_o <= 1'b1;
            end else begin
              state         <= BUSY;
              div_by_zero_o <= 1'b0;
            end
          end
        end
        BUSY: begin
          rem <= rem_next;
          quo <= quo_next;
          cnt <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= DONE;
            // floor quotient is all ones only for divisor 1, where the remainder is zero
            quotient_o <= quo_next + WIDTH'(rem_next != '0);
          end
        end
        DONE: begin
          if (out_ready_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CEIL_DIV_SEQ_ASSERTS_EN
  if (WIDTH < 2 || WIDTH > 64) begin : g_width_chk
    $error("ceil_div_seq: WIDTH must be in 2..64");
  end

  logic [WIDTH-1:0] dividend_q;
  logic [WIDTH:0]   ceil_ref;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)    dividend_q <= '0;
    else if (in_hs) dividend_q <= dividend_i;
  end

  assign ceil_ref = ({1'b0, dividend_q} + {1'b0, div} - 1'b1) / {1'b0, div};

  a_hold_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_valid_o && !out_ready_i |=> out_valid_o && $stable(quotient_o) && $stable(div_by_zero_o));

  a_ceil_result: assert property (@(posedge clk_i) disable iff (!rst_ni)
    out_valid_o && out_ready_i && !div_by_zero_o |-> ({1'b0, quotient_o} == ceil_ref));
`else
  // checker-free build: identical ports and cycle behaviour
`endif

endmodule

// File: tb/tb_ceil_div_seq.sv
// Self-checking bench for ceil_div_seq at WIDTH=8: directed timing cases plus a
// randomized back-to-back run, all results scored against a ceiling-division model.
module tb_ceil_div_seq;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] dividend = '0;
  logic [W-1:0] divisor = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] quotient;
  logic         dz;

  int tests = 0;
  int fails = 0;
  int n_in = 0;
  int n_out = 0;
  int n_abort = 0;
  logic [W:0] sb[$];

  always #5 clk = ~clk;

  ceil_div_seq #(.WIDTH(W)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .in_valid_i   (in_valid),
    .in_ready_o   (in_ready),
    .dividend_i   (dividend),
    .divisor_i    (divisor),
    .out_valid_o  (out_valid),
    .out_ready_i  (out_ready),
    .quotient_o   (quotient),
    .div_by_zero_o(dz)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // {div_by_zero, quotient}
  function automatic logic [W:0] model(input logic [W-1:0] a, input logic [W-1:0] b);
    int q;
    if (b == '0) return {1'b1, {W{1'b1}}};
    q = (int'(a) + int'(b) - 1) / int'(b);
    return {1'b0, q[W-1:0]};
  endfunction

  // inputs change only at posedge+1, so the negedge sees what the next edge will sample
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_valid && in_ready) begin
        sb.push_back(model(dividend, divisor));
        n_in++;
      end
      if (out_valid && out_ready) begin
        n_out++;
        if (sb.size() == 0) begin
          tests++;
          fails++;
          $error("FAIL sb_extra: observed result %0d expected no result", quotient);
        end else begin
          check("sb_result", {dz, quotient}, sb.pop_front());
        end
      end
    end
  end

  task automatic op(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                    input int exp_q, input int exp_dz, input int lat, input int hold);
    int k;
    bit got;
    logic [W-1:0] q0;
    logic         z0;
    @(posedge clk); #1;
    in_valid = 1'b1; dividend = a; divisor = b;
    @(negedge clk);
    check({tag, " in_ready"}, in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    k = 0;
    got = 0;
    while (!got && k < W + 6) begin
      @(negedge clk);
      k++;
      if (out_valid) got = 1;
    end
    check({tag, " latency"}, k, lat);
    check({tag, " quotient"}, quotient, exp_q);
    check({tag, " div_by_zero"}, dz, exp_dz);
    check({tag, " in_ready_busy"}, in_ready, 0);
    q0 = quotient;
    z0 = dz;
    for (int i = 1; i < hold; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, " hold_valid"}, out_valid, 1);
      check({tag, " hold_quotient"}, quotient, q0);
      check({tag, " hold_dz"}, dz, z0);
      check({tag, " hold_in_ready"}, in_ready, 0);
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check({tag, " accept_valid"}, out_valid, 1);
    check({tag, " accept_in_ready"}, in_ready, 0);
    @(posedge clk); #1;
    out_ready = 1'b0;
    @(negedge clk);
    check({tag, " after_in_ready"}, in_ready, 1);
    check({tag, " after_valid"}, out_valid, 0);
  endtask

  initial begin
    int cyc;
    int target;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst in_ready", in_ready, 1);
    check("rst out_valid", out_valid, 0);
    check("rst quotient", quotient, 0);
    check("rst div_by_zero", dz, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    op("7/2", 8'd7, 8'd2, 4, 0, 9, 0);
    op("8/2", 8'd8, 8'd2, 4, 0, 9, 0);
    op("0/5", 8'd0, 8'd5, 0, 0, 9, 0);
    op("255/1", 8'd255, 8'd1, 255, 0, 9, 0);
    op("255/254", 8'd255, 8'd254, 2, 0, 9, 0);
    op("10/0", 8'd10, 8'd0, 255, 1, 1, 3);
    op("100/7 backpressure", 8'd100, 8'd7, 15, 0, 9, 5);

    // reset in the middle of 200/3, four cycles after the handshake
    @(posedge clk); #1;
    in_valid = 1'b1; dividend = 8'd200; divisor = 8'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst out_valid", out_valid, 0);
    check("midrst in_ready", in_ready, 1);
    n_abort += sb.size();
    sb.delete();
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    op("200/3 after reset", 8'd200, 8'd3, 67, 0, 9, 0);

    // random back-to-back traffic with random backpressure
    cyc = 0;
    target = n_in + 1000;
    while (n_in < target && cyc < 40000) begin
      @(posedge clk); #1;
      in_valid  = 1'($urandom_range(0, 1));
      dividend  = 8'($urandom);
      divisor   = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      out_ready = 1'($urandom_range(0, 1));
      cyc++;
    end
    in_valid = 1'b0;
    check("rand budget", (n_in >= target), 1);
    out_ready = 1'b1;
    cyc = 0;
    while (sb.size() != 0 && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("drain empty", sb.size(), 0);
    check("no lost or duplicate", n_out, n_in - n_abort);
    check("final idle", in_ready, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/ceil_div_seq.md
CEIL_DIV_SEQ -- requirements
Module: ceil_div_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 32, operand and quotient width in bits (legal range 2..64).
REQ-002 SHALL have port clk_i  input  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port in_valid_i  input  1  operand pair valid.
REQ-005 SHALL have port in_ready_o  output  1  block can accept operands.
REQ-006 SHALL have port dividend_i  input  WIDTH  unsigned dividend.
REQ-007 SHALL have port divisor_i  input  WIDTH  unsigned divisor.
REQ-008 SHALL have port out_valid_o  output  1  result valid.
REQ-009 SHALL have port out_ready_i  input  1  consumer accepts result.
REQ-010 SHALL have port quotient_o  output  WIDTH  ceil(dividend/divisor).
REQ-011 SHALL have port div_by_zero_o  output  1  result came from a zero divisor; qualified by out_valid_o.

Function
REQ-012 SHALL implement states IDLE, BUSY, DONE; in_ready_o = 1 only in IDLE, combinational from state.
REQ-013 SHALL register dividend_i and divisor_i only on input handshake (in_valid_i & in_ready_o); inputs otherwise ignored.
REQ-014 SHALL, on handshake in cycle T with divisor != 0, go IDLE->BUSY and run one radix-2 restoring shift/subtract step per cycle for exactly WIDTH cycles.
REQ-015 SHALL hold an iteration counter of width cf_math_pkg::idx_width(WIDTH), cleared on handshake, incremented per BUSY cycle; BUSY->DONE when it reaches WIDTH-1.
REQ-016 SHALL keep partial remainder WIDTH+1 bits wide so no subtract step overflows.
REQ-017 SHALL on the final BUSY step register quotient_o = floor quotient + 1 if final remainder != 0, else floor quotient; out_valid_o first high in cycle T+WIDTH+1.
REQ-018 SHALL never overflow the ceiling increment (floor quotient = 2^WIDTH-1 only for divisor 1, where remainder is 0).
REQ-019 SHALL, on handshake with divisor == 0, go IDLE->DONE directly, quotient_o = all ones, div_by_zero_o = 1, out_valid_o high in cycle T+1.
REQ-020 SHALL hold quotient_o, div_by_zero_o, out_valid_o stable in DONE until out_ready_i = 1; then DONE->IDLE next edge.
REQ-021 SHALL not accept new operands in the cycle DONE is left (no bypass); earliest next handshake is the following cycle.
REQ-022 SHALL treat dividend 0 via the normal path, producing quotient 0 at T+WIDTH+1.

Reset
REQ-023 SHALL, while rst_ni = 0, force state IDLE, counter 0, quotient_o 0, div_by_zero_o 0, out_valid_o 0, internal operand/remainder registers 0; in_ready_o therefore 1.
REQ-024 SHALL abort any BUSY or DONE operation on reset without producing a result; first handshake possible in first cycle after deassertion.

Configuration
REQ-025 SHALL, with CEIL_DIV_SEQ_ASSERTS_EN defined, compile simulation assertions: out_valid_o/quotient_o/div_by_zero_o stable while out_valid_o & !out_ready_i; quotient_o equal to (dividend+divisor-1)/divisor computed at WIDTH+1 bits on each output handshake with divisor != 0; WIDTH in 2..64 at elaboration.
REQ-026 SHALL, without CEIL_DIV_SEQ_ASSERTS_EN, contain no assertion logic; port list and cycle behaviour identical.

Verification (WIDTH=8, handshake in cycle T)
REQ-027 SHALL check 7/2 -> quotient_o 4, div_by_zero_o 0, out_valid_o first high at T+9; 8/2 -> 4 at T+9.
REQ-028 SHALL check 0/5 -> 0 and 255/1 -> 255 and 255/254 -> 2, each at T+9.
REQ-029 SHALL check 10/0 -> quotient_o 255, div_by_zero_o 1 at T+1, in_ready_o 0 until accepted.
REQ-030 SHALL check backpressure: out_ready_i low 5 cycles after result -> outputs stable, in_ready_o 0; result accepted on 6th cycle, in_ready_o 1 next cycle.
REQ-031 SHALL check reset: rst_ni low at T+4 during 200/3 -> out_valid_o 0, in_ready_o 1 immediately; after release 200/3 -> 67 at new T+9.
REQ-032 SHALL check back-to-back: random 1000 pairs incl. divisor 0, out_ready_i random -> every quotient matches ceiling model, no lost or duplicated result.
